i_sram_nport: RTL and testbench

I_SRAM_NPORT -- requirements
Module: i_sram_nport

---
 rtl/i_sram_nport.sv | 173 +++++++++++++++++
 tb/tb_i_sram_nport.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i_sram_nport.sv
// ---------------------------------------------------------------------------
// i_sram_nport -- instruction SRAM with a lane-serial load port and two
// independent registered read ports.
//
// A line of LANES lanes (LANE_W bits each, lane 0 in the LSBs) is loaded one
// lane per beat through a ld_valid/ld_ready handshake, assembled in a line
// buffer, then written to memory in a single COMMIT cycle (ld_done pulses).
// Each read port returns a full line one cycle after rd_en.
//
// Ports:
//   clock               sole clock, rising edge
//   reset               synchronous, active-low
//   ld_valid/ld_ready   load beat handshake
//   ld_addr             target line, sampled on the first beat only
//   ld_data             one lane per beat, lane 0 first
//   ld_done             one-cycle pulse in the COMMIT cycle
//   rd_en1/rd_en2       read requests
//   rd_addr1/rd_addr2   read line addresses
//   rd_data1/rd_data2   registered read lines (held while rd_en is low)
//   rd_valid1/rd_valid2 rd_data updated this cycle
//
// Build option:
//   I_SRAM_NPORT_RD_BYPASS_EN  when defined, a read issued in the COMMIT
//                              cycle to the committing address returns the
//                              new line; otherwise it returns the old line.
// ---------------------------------------------------------------------------
module i_sram_nport #(
    parameter int LANE_W = 48,
    parameter int LANES  = 5,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [LANE_W-1:0]         ld_data,
    output logic                      ld_done,
    input  logic                      rd_en1,
    input  logic [ADDR_W-1:0]         rd_addr1,
    output logic [LANES*LANE_W-1:0]   rd_data1,
    output logic                      rd_valid1,
    input  logic                      rd_en2,
    input  logic [ADDR_W-1:0]         rd_addr2,
    output logic [LANES*LANE_W-1:0]   rd_data2,
    output logic                      rd_valid2
);

    localparam int LW    = LANES * LANE_W;
    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LW-1:0]       line_q,  line_d;
    logic [LW-1:0]       rd_data1_q, rd_data2_q;
    logic                rd_valid1_q, rd_valid2_q;
    logic                commit_we;

    logic [LW-1:0]       mem_q [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic [LW-1:0] read_line(input logic [ADDR_W-1:0] a);
        if (!in_range(a)) begin
            return '0;
        end
`ifdef I_SRAM_NPORT_RD_BYPASS_EN
        // Forward the line being committed this cycle.
        if (commit_we && (a == addr_q)) begin
            return line_q;
        end
`endif
        return mem_q[a[IDX_W-1:0]];
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            rd_data1_q  <= '0;
            rd_data2_q  <= '0;
            rd_valid1_q <= 1'b0;
            rd_valid2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            rd_valid1_q <= rd_en1;
            rd_valid2_q <= rd_en2;
            if (rd_en1) begin
                rd_data1_q <= read_line(rd_addr1);
            end
            if (rd_en2) begin
                rd_data2_q <= read_line(rd_addr2);
            end
        end
    end

    // Memory array is intentionally not reset.
    always_ff @(posedge clock) begin
        if (commit_we) begin
            mem_q[addr_q[IDX_W-1:0]] <= line_q;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    addr_d                = ld_addr;
                    line_d[LANE_W-1:0]    = ld_data;
                    count_d               = CNT_W'(1);
                    state_d               = (LANES == 1) ? COMMIT : FILL;
                end
            end
            FILL: begin
                if (ld_valid) begin
                    line_d[count_q*LANE_W +: LANE_W] = ld_data;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_BEAT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    // Qualify with reset so a reset landing on COMMIT neither writes nor
    // signals completion.
    always_comb begin
        ld_ready  = (state_q != COMMIT);
        ld_done   = (state_q == COMMIT) && reset;
        commit_we = (state_q == COMMIT) && reset && in_range(addr_q);
    end

    assign rd_data1  = rd_data1_q;
    assign rd_data2  = rd_data2_q;
    assign rd_valid1 = rd_valid1_q;
    assign rd_valid2 = rd_valid2_q;

endmodule

// File: tb/tb_i_sram_nport.sv
module tb_i_sram_nport;

    localparam int LANE_W = 48;
    localparam int LANES  = 5;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int LW     = LANES * LANE_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [LANE_W-1:0] ld_data;
    logic              ld_done;
    logic              rd_en1, rd_en2;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic [LW-1:0]     rd_data1, rd_data2;
    logic              rd_valid1, rd_valid2;

    int tests = 0;
    int fails = 0;

    logic [LW-1:0] q1[$];
    logic [LW-1:0] q2[$];
    logic [LW-1:0] model[int];

    i_sram_nport #(
        .LANE_W(LANE_W),
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_valid1(rd_valid1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .rd_valid2(rd_valid2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Line whose lane i holds base+i.
    function automatic logic [LW-1:0] mk_line(input int base);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < LANES; i++) l[i*LANE_W +: LANE_W] = LANE_W'(base + i);
        return l;
    endfunction

    function automatic logic [LW-1:0] expect_rd(input int a);
        if (a >= DEPTH || !model.exists(a)) return '0;
        return model[a];
    endfunction

    // Scoreboard monitor: pops one expectation per valid read result.
    always @(negedge clock) begin
        if (rd_valid1 === 1'b1) begin
            if (q1.size() == 0) chk("rd1_unexpected_valid", 1, 0);
            else chk("rd1_data", rd_data1, q1.pop_front());
        end
        if (rd_valid2 === 1'b1) begin
            if (q2.size() == 0) chk("rd2_unexpected_valid", 1, 0);
            else chk("rd2_data", rd_data2, q2.pop_front());
        end
    end

    task automatic do_read(input logic e1, input int a1, input logic e2, input int a2);
        rd_en1 = e1; rd_addr1 = ADDR_W'(a1);
        rd_en2 = e2; rd_addr2 = ADDR_W'(a2);
        if (e1) q1.push_back(expect_rd(a1));
        if (e2) q2.push_back(expect_rd(a2));
        tick();
        rd_en1 = 1'b0;
        rd_en2 = 1'b0;
    endtask

    // Loads a line; optional idle gap before beat gap_at; optional port-1
    // read of the same address during the COMMIT cycle.
    task automatic load_line(input int a, input logic [LW-1:0] line,
                             input int gap_at, input int gap_len, input bit commit_rd);
        for (int b = 0; b < LANES; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    ld_valid = 1'b0;
                    tick();
                    chk("fill_gap_ready", LW'(ld_ready), LW'(1));
                end
            end
            chk("beat_ready", LW'(ld_ready), LW'(1));
            ld_valid = 1'b1;
            ld_addr  = (b == 0) ? ADDR_W'(a) : '1;
            ld_data  = line[b*LANE_W +: LANE_W];
            tick();
        end
        ld_valid = 1'b0;
        chk("commit_done", LW'(ld_done), LW'(1));
        chk("commit_not_ready", LW'(ld_ready), LW'(0));
        if (commit_rd) begin
            rd_en1   = 1'b1;
            rd_addr1 = ADDR_W'(a);
`ifdef I_SRAM_NPORT_RD_BYPASS_EN
            q1.push_back(line);
`else
            q1.push_back(expect_rd(a));
`endif
        end
        if (a < DEPTH) model[a] = line;
        tick();
        rd_en1 = 1'b0;
        chk("done_one_cycle", LW'(ld_done), LW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_ld_ready", LW'(ld_ready), LW'(1));
        chk("rst_ld_done", LW'(ld_done), LW'(0));
        chk("rst_rd_valid1", LW'(rd_valid1), LW'(0));
        chk("rst_rd_valid2", LW'(rd_valid2), LW'(0));
        chk("rst_rd_data1", rd_data1, '0);
        chk("rst_rd_data2", rd_data2, '0);

        // Prior contents for 0x30, used by the aborted-load check.
        load_line(32'h30, mk_line(32'h31), -1, 0, 1'b0);

        // Back-to-back beats 1..5 into 0x12, then read it.
        load_line(32'h12, mk_line(1), -1, 0, 1'b0);
        do_read(1'b1, 32'h12, 1'b0, 0);
        #1;
        // Port 1 idle: data holds, valid low.
        tick();
        chk("hold_valid1", LW'(rd_valid1), LW'(0));
        chk("hold_data1", rd_data1, mk_line(1));

        // Stalled load: 3 idle cycles before the third beat.
        load_line(32'h20, mk_line(32'h21), 2, 3, 1'b0);

        // Dual-port reads of different, then identical addresses.
        do_read(1'b1, 32'h12, 1'b1, 32'h20);
        do_read(1'b1, 32'h20, 1'b1, 32'h20);
        do_read(1'b1, 32'h30, 1'b0, 0);

        // Out-of-range address: commit dropped but ld_done pulses; reads 0.
        load_line(32'hF0, mk_line(32'h77), -1, 0, 1'b0);
        do_read(1'b1, 32'hF0, 1'b1, 32'hC7);

        // Reload 0x12 with 0xA..0xE, reading 0x12 during COMMIT.
        load_line(32'h12, mk_line(32'hA), -1, 0, 1'b1);
        do_read(1'b0, 0, 1'b1, 32'h12);

        // Three beats to 0x30, then reset: partial line discarded.
        for (int b = 0; b < 3; b++) begin
            ld_valid = 1'b1;
            ld_addr  = 8'h30;
            ld_data  = LANE_W'(32'h41 + b);
            tick();
        end
        ld_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_done", LW'(ld_done), LW'(0));
            tick();
        end
        do_read(1'b1, 32'h30, 1'b1, 32'h30);

        tick();
        tick();
        chk("sb_drain", LW'(q1.size() + q2.size()), LW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
